// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator: position, sync, blanking and strobes, all registered together.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int POS_BITS   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_ce,
    output logic [POS_BITS-1:0] hpos,
    output logic [POS_BITS-1:0] vpos,
    output logic                display_on,
    output logic                vga_h_sync,
    output logic                vga_v_sync,
    output logic                line_start,
    output logic                frame_start,
    output logic                vblank_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_BITS-1:0] H_LAST   = POS_BITS'(H_TOTAL - 1);
    localparam logic [POS_BITS-1:0] V_LAST   = POS_BITS'(V_TOTAL - 1);
    localparam logic [POS_BITS-1:0] H_ACT    = POS_BITS'(H_ACTIVE);
    localparam logic [POS_BITS-1:0] V_ACT    = POS_BITS'(V_ACTIVE);
    localparam logic [POS_BITS-1:0] HS_BEGIN = POS_BITS'(H_ACTIVE + H_FRONT);
    localparam logic [POS_BITS-1:0] HS_END   = POS_BITS'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [POS_BITS-1:0] VS_BEGIN = POS_BITS'(V_ACTIVE + V_FRONT);
    localparam logic [POS_BITS-1:0] VS_END   = POS_BITS'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic                H_ASSERT = (H_SYNC_POL != 0);
    localparam logic                V_ASSERT = (V_SYNC_POL != 0);

    // A non-empty back porch keeps the reset position (last pixel) outside sync and active video.
    if (H_BACK < 1) begin : g_chk_h_back
        $error("vga_timing_generator: H_BACK must be >= 1");
    end
    if (V_BACK < 1) begin : g_chk_v_back
        $error("vga_timing_generator: V_BACK must be >= 1");
    end
    if (H_TOTAL > (1 << POS_BITS)) begin : g_chk_h_fit
        $error("vga_timing_generator: H_TOTAL-1 does not fit in POS_BITS");
    end
    if (V_TOTAL > (1 << POS_BITS)) begin : g_chk_v_fit
        $error("vga_timing_generator: V_TOTAL-1 does not fit in POS_BITS");
    end

    logic [POS_BITS-1:0] hpos_q, hpos_d;
    logic [POS_BITS-1:0] vpos_q, vpos_d;
    logic                display_on_q, display_on_d;
    logic                h_sync_q, h_sync_d;
    logic                v_sync_q, v_sync_d;
    logic                line_start_q, line_start_d;
    logic                frame_start_q, frame_start_d;
    logic                vblank_start_q, vblank_start_d;

    // Every decoded output is derived from the next position so it lands with it on the same edge.
    always_comb begin
        hpos_d         = hpos_q;
        vpos_d         = vpos_q;
        display_on_d   = display_on_q;
        h_sync_d       = h_sync_q;
        v_sync_d       = v_sync_q;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;

        if (pix_ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end

            display_on_d   = (hpos_d < H_ACT) && (vpos_d < V_ACT);
            h_sync_d       = ((hpos_d >= HS_BEGIN) && (hpos_d <= HS_END)) ? H_ASSERT : ~H_ASSERT;
            v_sync_d       = ((vpos_d >= VS_BEGIN) && (vpos_d <= VS_END)) ? V_ASSERT : ~V_ASSERT;
            line_start_d   = (hpos_d == '0);
            frame_start_d  = (hpos_d == '0) && (vpos_d == '0);
            vblank_start_d = (hpos_d == '0) && (vpos_d == V_ACT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q         <= H_LAST;
            vpos_q         <= V_LAST;
            display_on_q   <= 1'b0;
            h_sync_q       <= ~H_ASSERT;
            v_sync_q       <= ~V_ASSERT;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hpos_q         <= hpos_d;
            vpos_q         <= vpos_d;
            display_on_q   <= display_on_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign display_on   = display_on_q;
    assign vga_h_sync   = h_sync_q;
    assign vga_v_sync   = v_sync_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
